// File: rtl/register_file.sv
// register_file: multi-entry register file for the LITE-16 datapath.
// One synchronous write port with byte-lane enables, two independent
// combinational read ports, optional hardwired-zero entry 0 and optional
// same-cycle write-to-read bypass.
module register_file #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned NB      = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [NB-1:0]    wbe,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    // DEPTH widened by one bit so DEPTH = 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_waddr_in_range;
    logic             w_waddr_zero_blocked;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_wr_old;
    logic [WIDTH-1:0] w_wr_merged;

    // A write is accepted only out of reset, in range, and not to a hardwired zero entry.
    assign w_waddr_in_range     = ({1'b0, waddr} < DEPTH_W);
    assign w_waddr_zero_blocked = ZERO_REG && (waddr == '0);
    assign w_wr_ok              = rst && we && w_waddr_in_range && !w_waddr_zero_blocked;

    // Current contents of the addressed write entry (0 when out of range).
    always_comb begin
        w_wr_old = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (waddr == AW'(i)) begin
                w_wr_old = r_mem[i];
            end
        end
    end

    // Post-edge value of the write entry: enabled lanes from wdata, others kept.
    always_comb begin
        w_wr_merged = w_wr_old;
        for (int unsigned b = 0; b < NB; b++) begin
            if (wbe[b]) begin
                w_wr_merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // Storage: reset clears every entry and wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (waddr == AW'(i)) begin
                    r_mem[i] <= w_wr_merged;
                end
            end
        end
    end

    // Read port A: stored entry, zero for out-of-range/zero entry, bypass on match.
    always_comb begin
        rdata_a = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) begin
                rdata_a = r_mem[i];
            end
        end
        if (ZERO_REG && (raddr_a == '0)) begin
            rdata_a = '0;
        end
        if (BYPASS && w_wr_ok && (raddr_a == waddr)) begin
            rdata_a = w_wr_merged;
        end
    end

    // Read port B: same rules as port A, fully independent.
    always_comb begin
        rdata_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (raddr_b == AW'(i)) begin
                rdata_b = r_mem[i];
            end
        end
        if (ZERO_REG && (raddr_b == '0)) begin
            rdata_b = '0;
        end
        if (BYPASS && w_wr_ok && (raddr_b == waddr)) begin
            rdata_b = w_wr_merged;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: two register_file instances driven by shared inputs,
// dut0 with defaults (DEPTH=8, ZERO_REG=1, BYPASS=1) and dut1 with
// DEPTH=6, ZERO_REG=0, BYPASS=0, checked against an array-based model.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [1:0]  wbe;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] rdata_a0;
    logic [15:0] rdata_b0;
    logic [15:0] rdata_a1;
    logic [15:0] rdata_b1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    // Model configuration and contents, index 0 = dut0, 1 = dut1.
    int          depth_c [2] = '{8, 6};
    bit          zr_c    [2] = '{1'b1, 1'b0};
    bit          bp_c    [2] = '{1'b1, 1'b0};
    logic [15:0] mem     [2][8];

    register_file u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a0), .raddr_b(raddr_b), .rdata_b(rdata_b0)
    );

    register_file #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a1), .raddr_b(raddr_b), .rdata_b(rdata_b1)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit wr_valid(int c);
        return (rst === 1'b1) && (we === 1'b1) && (int'(waddr) < depth_c[c])
               && !(zr_c[c] && waddr == 3'd0);
    endfunction

    function automatic logic [15:0] merge(logic [15:0] old_v);
        logic [15:0] v;
        v = old_v;
        if (wbe[0]) v[7:0]  = wdata[7:0];
        if (wbe[1]) v[15:8] = wdata[15:8];
        return v;
    endfunction

    function automatic logic [15:0] model_read(int c, int addr);
        if (addr >= depth_c[c]) return 16'h0000;
        if (zr_c[c] && addr == 0) return 16'h0000;
        if (bp_c[c] && wr_valid(c) && addr == int'(waddr)) return merge(mem[c][addr]);
        return mem[c][addr];
    endfunction

    // Drive one cycle's inputs at the falling edge and check all four read ports.
    task automatic apply(input logic r, input logic w, input logic [2:0] wa, input logic [1:0] be,
                         input logic [15:0] wd, input logic [2:0] ra, input logic [2:0] rb);
        @(negedge clk);
        rst = r; we = w; waddr = wa; wbe = be; wdata = wd; raddr_a = ra; raddr_b = rb;
        #1;
        exp_q.push_back(model_read(0, int'(ra)));
        exp_q.push_back(model_read(0, int'(rb)));
        exp_q.push_back(model_read(1, int'(ra)));
        exp_q.push_back(model_read(1, int'(rb)));
        check_eq("d0_rdata_a", rdata_a0, exp_q.pop_front());
        check_eq("d0_rdata_b", rdata_b0, exp_q.pop_front());
        check_eq("d1_rdata_a", rdata_a1, exp_q.pop_front());
        check_eq("d1_rdata_b", rdata_b1, exp_q.pop_front());
    endtask

    // Advance through the rising edge and update the model.
    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (rst === 1'b0) begin
                for (int i = 0; i < 8; i++) mem[c][i] = 16'h0000;
            end else if (wr_valid(c)) begin
                mem[c][waddr] = merge(mem[c][waddr]);
            end
        end
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = '0; wbe = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        tick();
        tick();

        // Reset discards a simultaneous write and clears everything.
        for (int i = 1; i < 8; i++) begin
            apply(1'b1, 1'b1, 3'(i), 2'b11, 16'hFFFF, 3'(i), 3'd0);
            tick();
        end
        apply(1'b0, 1'b1, 3'd3, 2'b11, 16'h1234, 3'd3, 3'd3);
        check_eq("rst_hold_stored", rdata_a0, 16'hFFFF);
        tick();
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b0, 3'd0, 2'b00, 16'h0000, 3'(i), 3'(7 - i));
            check_eq("rst_clear_d0", rdata_a0, 16'h0000);
            check_eq("rst_clear_d1", rdata_a1, 16'h0000);
            tick();
        end

        // Full-word write, then we=0 must not modify.
        apply(1'b1, 1'b1, 3'd5, 2'b11, 16'hAABB, 3'd5, 3'd4);
        tick();
        apply(1'b1, 1'b0, 3'd5, 2'b11, 16'hAA00, 3'd5, 3'd4);
        check_eq("wr_e5", rdata_a0, 16'hAABB);
        check_eq("wr_e4", rdata_b0, 16'h0000);
        tick();
        apply(1'b1, 1'b0, 3'd0, 2'b00, 16'h0000, 3'd5, 3'd5);
        check_eq("we0_keep", rdata_a0, 16'hAABB);
        tick();

        // Byte lanes.
        apply(1'b1, 1'b1, 3'd2, 2'b11, 16'hAABB, 3'd2, 3'd2);
        tick();
        apply(1'b1, 1'b1, 3'd2, 2'b01, 16'h1122, 3'd2, 3'd2);
        check_eq("lane_lo_bypass", rdata_a0, 16'hAA22);
        tick();
        apply(1'b1, 1'b1, 3'd2, 2'b10, 16'h33FF, 3'd2, 3'd2);
        check_eq("lane_hi_bypass", rdata_b0, 16'h3322);
        check_eq("lane_lo_stored", rdata_a1, 16'hAA22);
        tick();
        apply(1'b1, 1'b1, 3'd2, 2'b00, 16'hFFFF, 3'd2, 3'd2);
        check_eq("lane_none", rdata_a1, 16'h3322);
        tick();

        // Zero register and out-of-range address.
        apply(1'b1, 1'b1, 3'd0, 2'b11, 16'hBEEF, 3'd0, 3'd0);
        check_eq("zr_bypass", rdata_a0, 16'h0000);
        tick();
        apply(1'b1, 1'b1, 3'd7, 2'b11, 16'h5678, 3'd0, 3'd7);
        check_eq("zr_d0", rdata_a0, 16'h0000);
        check_eq("zr_off_d1", rdata_a1, 16'hBEEF);
        check_eq("oor_d1", rdata_b1, 16'h0000);
        tick();
        apply(1'b1, 1'b0, 3'd0, 2'b00, 16'h0000, 3'd7, 3'd6);
        check_eq("oor_wr_d0", rdata_a0, 16'h5678);
        check_eq("oor_rd_d1", rdata_a1, 16'h0000);
        tick();

        // Bypass versus stored-only read.
        apply(1'b1, 1'b1, 3'd5, 2'b11, 16'h0F0F, 3'd0, 3'd0);
        tick();
        apply(1'b1, 1'b1, 3'd5, 2'b10, 16'hA5A5, 3'd5, 3'd5);
        check_eq("bp_on_a", rdata_a0, 16'hA50F);
        check_eq("bp_off_a", rdata_a1, 16'h0F0F);
        check_eq("bp_off_b", rdata_b1, 16'h0F0F);
        tick();
        apply(1'b1, 1'b0, 3'd0, 2'b00, 16'h0000, 3'd5, 3'd5);
        check_eq("bp_off_after", rdata_a1, 16'hA50F);
        tick();
        apply(1'b1, 1'b1, 3'd6, 2'b11, 16'h0F0F, 3'd0, 3'd0);
        tick();
        apply(1'b1, 1'b1, 3'd6, 2'b10, 16'hA5A5, 3'd6, 3'd6);
        check_eq("bp_e6_a", rdata_a0, 16'hA50F);
        check_eq("bp_e6_b", rdata_b0, 16'hA50F);
        tick();

        // Reset in the middle of a write stream to entry 1.
        for (int v = 1; v <= 8; v++) begin
            apply((v != 5), 1'b1, 3'd1, 2'b11, 16'(v), 3'd1, 3'd6);
            if (v == 5) check_eq("mid_rst_nobypass", rdata_a0, 16'h0004);
            if (v == 6) begin
                check_eq("mid_rst_cleared", rdata_a1, 16'h0000);
                check_eq("mid_rst_e6", rdata_b0, 16'h0000);
            end
            tick();
        end
        apply(1'b1, 1'b0, 3'd0, 2'b00, 16'h0000, 3'd1, 3'd1);
        check_eq("stream_last", rdata_a1, 16'h0008);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
